// File: rtl/uart_echo_buffer_pkg.sv
// uart_echo_buffer_pkg: shared definitions for the echo buffer.
// Holds the issue FSM state encoding, ASCII case-fold constants and the fold helper.
package uart_echo_buffer_pkg;

  // Issue FSM states (3-bit encoding)
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_SEND      = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_DONE = 3'd4
  } issue_state_e;

  localparam logic [7:0] ASCII_LC_A        = 8'h61;
  localparam logic [7:0] ASCII_LC_Z        = 8'h7A;
  localparam logic [7:0] ASCII_CASE_OFFSET = 8'h20;

  // Lower-case letters become upper case; every other byte passes unchanged.
  function automatic logic [7:0] fold_case(input logic [7:0] b);
    if ((b >= ASCII_LC_A) && (b <= ASCII_LC_Z)) begin
      return b - ASCII_CASE_OFFSET;
    end
    return b;
  endfunction

endpackage

// File: rtl/uart_echo_buffer_byte_fifo.sv
// byte_fifo: 2**DEPTH_LOG2 x 8 FIFO with synchronous write and registered read.
// A push while full is accepted only when a pop happens in the same cycle.
// A pop while empty is ignored. empty/full are decoded from the occupancy count.
module byte_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [7:0]            din,
  output logic [7:0]            dout,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  full
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

  logic [7:0]            mem_q [DEPTH];
  logic [7:0]            dout_q;
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  wr_en;
  logic                  rd_en;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_COUNT);
  assign rd_en = pop & ~empty;
  // When full, the slot being read this cycle frees room for the incoming byte.
  assign wr_en = push & (~full | rd_en);

  // Storage array: no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // Registered read port; on a same-address write the old head value is returned
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout_q <= '0;
    end else if (rd_en) begin
      dout_q <= mem_q[rd_ptr_q];
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  assign dout  = dout_q;
  assign count = count_q;

endmodule

// File: rtl/uart_echo_buffer.sv
// uart_echo_buffer: elastic byte buffer between uart_receive and uart_transmitter.
// Captures bytes on the rising edge of rx_ready, acknowledges one cycle after the
// write, queues them in byte_fifo and issues them to the transmitter whenever it is idle.
// Optional feature macro CASE_FOLD_EN: when defined, 'a'..'z' are stored as upper case.
module uart_echo_buffer
  import uart_echo_buffer_pkg::*;
#(
  parameter int DEPTH_LOG2   = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_ready,
  output logic                  rx_reset_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_send,
  input  logic                  tx_busy,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow
);

  localparam int TIMER_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(BUSY_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);

  logic                rx_ready_q;
  logic                ack_pend_q;
  logic                rx_reset_ready_q;
  logic                overflow_q;
  logic                overflow_d;
  logic                tx_send_q;
  issue_state_e        state_q;
  logic [TIMER_W-1:0]  timer_q;

  logic                push;
  logic                pop;
  logic [7:0]          store_byte;
  logic [7:0]          fifo_dout;
  logic [DEPTH_LOG2:0] fifo_cnt;
  logic                fifo_empty;
  logic                fifo_full;

  // A byte is taken only on the low-to-high transition of the ready level.
  assign push = rx_ready & ~rx_ready_q;
  assign pop  = (state_q == ST_LOAD);

`ifdef CASE_FOLD_EN
  assign store_byte = fold_case(rx_data);
`else
  assign store_byte = rx_data;
`endif

  // Dropped bytes only come from a full FIFO that is not draining this cycle.
  assign overflow_d = overflow_q | (push & fifo_full & ~pop);

  // Ready edge detect (starts high so a level already up at reset is ignored) and delayed ack
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_ready_q       <= 1'b1;
      ack_pend_q       <= 1'b0;
      rx_reset_ready_q <= 1'b0;
    end else begin
      rx_ready_q       <= rx_ready;
      ack_pend_q       <= push;
      rx_reset_ready_q <= ack_pend_q;
    end
  end

  // Sticky overflow flag, cleared only by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  // Issue FSM: pop head, strobe send, then wait for the transmitter busy cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      tx_send_q <= 1'b0;
    end else begin
      tx_send_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (!fifo_empty && !tx_busy) begin
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          state_q   <= ST_SEND;
          tx_send_q <= 1'b1;
        end
        ST_SEND: begin
          state_q <= ST_WAIT_BUSY;
          timer_q <= '0;
        end
        ST_WAIT_BUSY: begin
          // A transmitter that never goes busy costs this byte, not the queue.
          if (tx_busy) begin
            state_q <= ST_WAIT_DONE;
          end else if (timer_q == TIMER_LAST) begin
            state_q <= ST_IDLE;
          end else begin
            timer_q <= timer_q + TIMER_ONE;
          end
        end
        ST_WAIT_DONE: begin
          if (!tx_busy) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  byte_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     (store_byte),
    .dout    (fifo_dout),
    .count   (fifo_cnt),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  // The FIFO read register only changes on a LOAD pop, so it holds tx_data steady.
  assign tx_data        = fifo_dout;
  assign tx_send        = tx_send_q;
  assign rx_reset_ready = rx_reset_ready_q;
  assign fifo_count     = fifo_cnt;
  assign empty          = fifo_empty;
  assign full           = fifo_full;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_uart_echo_buffer.sv
// tb_uart_echo_buffer: scenario tasks with randomized bytes; expected output stream
// is an ordered list of stored bytes (optionally case-folded) built by the bench.
module tb_uart_echo_buffer;

  localparam int DEPTH_LOG2   = 4;
  localparam int BUSY_TIMEOUT = 16;
  localparam int DEPTH        = 1 << DEPTH_LOG2;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [7:0]          rx_data;
  logic                rx_ready;
  logic                rx_reset_ready;
  logic [7:0]          tx_data;
  logic                tx_send;
  logic                tx_busy;
  logic [DEPTH_LOG2:0] fifo_count;
  logic                empty;
  logic                full;
  logic                overflow;

  logic force_busy;
  logic model_busy;
  bit   tx_auto;
  int   tx_delay;
  int   tx_len;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  logic [7:0] sent_q[$];
  int         send_cyc[$];
  logic [7:0] exp_q[$];

  assign tx_busy = force_busy | model_busy;

  uart_echo_buffer #(
    .DEPTH_LOG2   (DEPTH_LOG2),
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .rx_data        (rx_data),
    .rx_ready       (rx_ready),
    .rx_reset_ready (rx_reset_ready),
    .tx_data        (tx_data),
    .tx_send        (tx_send),
    .tx_busy        (tx_busy),
    .fifo_count     (fifo_count),
    .empty          (empty),
    .full           (full),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: records every send; optionally goes busy tx_delay cycles later for tx_len cycles
  initial begin
    model_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_send === 1'b1) begin
        sent_q.push_back(tx_data);
        send_cyc.push_back(cyc);
        $display("[%0d] tx byte %h", cyc, tx_data);
        if (tx_auto) begin
          repeat (tx_delay) @(posedge clk);
          #1 model_busy = 1'b1;
          repeat (tx_len) @(posedge clk);
          #1 model_busy = 1'b0;
        end
      end
    end
  end

  // Value the buffer is expected to store for a received byte
  function automatic logic [7:0] ref_store(input logic [7:0] b);
`ifdef CASE_FOLD_EN
    if (b >= 8'd97 && b <= 8'd122) return b - 8'd32;
`endif
    return b;
  endfunction

  // Receiver handshake: raise ready, wait for the ack, drop ready
  task automatic rx_byte(input logic [7:0] b);
    int n;
    @(posedge clk); #1;
    rx_data  = b;
    rx_ready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (rx_reset_ready !== 1'b1 && n < 8);
    n_checks++; if (rx_reset_ready !== 1'b1) $display("FAIL rx_ack: byte %h got rx_reset_ready=%b required 1", b, rx_reset_ready); else n_pass++;
    @(posedge clk); #1;
    rx_ready = 1'b0;
  endtask

  task automatic wait_sent(input int k, input int bound);
    int n;
    n = 0;
    while (sent_q.size() < k && n < bound) begin @(negedge clk); n++; end
  endtask

  task automatic do_reset;
    int n;
    @(posedge clk); #1;
    reset_n = 1'b0; rx_ready = 1'b0; force_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    n = 0;
    while (model_busy && n < 100) begin @(negedge clk); n++; end
    sent_q.delete(); send_cyc.delete(); exp_q.delete();
  endtask

  task automatic test_reset;
    reset_n = 1'b0; rx_ready = 1'b0; rx_data = 8'h00; force_busy = 1'b0;
    tx_auto = 1'b0; tx_delay = 2; tx_len = 4;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    n_checks++; if (tx_send !== 1'b0) $display("FAIL reset_tx_send: got %b required 0", tx_send); else n_pass++;
    n_checks++; if (rx_reset_ready !== 1'b0) $display("FAIL reset_ack: got %b required 0", rx_reset_ready); else n_pass++;
    n_checks++; if (fifo_count !== 0) $display("FAIL reset_count: got %0d required 0", fifo_count); else n_pass++;
    n_checks++; if (empty !== 1'b1 || full !== 1'b0) $display("FAIL reset_flags: got empty=%b full=%b required 1/0", empty, full); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b required 0", overflow); else n_pass++;
    n_checks++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h required 00", tx_data); else n_pass++;
  endtask

  task automatic test_single_byte;
    do_reset;
    tx_auto = 1'b1; tx_delay = 2; tx_len = 20;
    @(posedge clk); #1 rx_data = 8'h8E; rx_ready = 1'b1;
    @(negedge clk);                 // before the capture edge
    @(negedge clk);                 // cycle N: byte written
    n_checks++; if (fifo_count !== 1) $display("FAIL single_count_n: got %0d required 1", fifo_count); else n_pass++;
    n_checks++; if (rx_reset_ready !== 1'b0) $display("FAIL single_ack_n: got %b required 0", rx_reset_ready); else n_pass++;
    @(negedge clk);                 // cycle N+1: ack, LOAD
    n_checks++; if (rx_reset_ready !== 1'b1) $display("FAIL single_ack_n1: got %b required 1", rx_reset_ready); else n_pass++;
    n_checks++; if (tx_send !== 1'b0) $display("FAIL single_send_n1: got %b required 0", tx_send); else n_pass++;
    @(posedge clk); #1 rx_ready = 1'b0;
    @(negedge clk);                 // cycle N+2: send
    n_checks++; if (tx_send !== 1'b1) $display("FAIL single_send_n2: got %b required 1", tx_send); else n_pass++;
    n_checks++; if (tx_data !== ref_store(8'h8E)) $display("FAIL single_data: got %h required %h", tx_data, ref_store(8'h8E)); else n_pass++;
    n_checks++; if (rx_reset_ready !== 1'b0) $display("FAIL single_ack_n2: got %b required 0", rx_reset_ready); else n_pass++;
    n_checks++; if (fifo_count !== 0 || empty !== 1'b1) $display("FAIL single_drain: got count=%0d empty=%b required 0/1", fifo_count, empty); else n_pass++;
    @(negedge clk);
    n_checks++; if (tx_send !== 1'b0) $display("FAIL single_send_pulse: got %b required 0", tx_send); else n_pass++;
    repeat (30) @(negedge clk);
    n_checks++; if (sent_q.size() != 1) $display("FAIL single_sent_count: got %0d required 1", sent_q.size()); else n_pass++;
  endtask

  task automatic test_burst;
    do_reset;
    tx_auto = 1'b1; tx_delay = 2; tx_len = 3;
    @(posedge clk); #1 force_busy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rx_byte(8'(i));
      if (i < DEPTH) exp_q.push_back(ref_store(8'(i)));
    end
    @(negedge clk);
    n_checks++; if (fifo_count !== DEPTH) $display("FAIL burst_count: got %0d required %0d", fifo_count, DEPTH); else n_pass++;
    n_checks++; if (full !== 1'b1 || empty !== 1'b0) $display("FAIL burst_flags: got full=%b empty=%b required 1/0", full, empty); else n_pass++;
    n_checks++; if (overflow !== 1'b1) $display("FAIL burst_overflow: got %b required 1", overflow); else n_pass++;
    @(posedge clk); #1 force_busy = 1'b0;
    wait_sent(DEPTH, 2000);
    n_checks++; if (sent_q.size() != DEPTH) $display("FAIL burst_sent_count: got %0d required %0d", sent_q.size(), DEPTH); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++) begin
      n_checks++; if (sent_q[i] !== exp_q[i]) $display("FAIL burst_order[%0d]: got %h required %h", i, sent_q[i], exp_q[i]); else n_pass++;
    end
    repeat (10) @(negedge clk);
    n_checks++; if (empty !== 1'b1 || fifo_count !== 0) $display("FAIL burst_empty: got empty=%b count=%0d required 1/0", empty, fifo_count); else n_pass++;
    n_checks++; if (overflow !== 1'b1) $display("FAIL burst_sticky: got %b required 1", overflow); else n_pass++;
  endtask

  task automatic test_simultaneous;
    logic [7:0] b;
    int n;
    do_reset;
    tx_auto = 1'b1; tx_delay = 2; tx_len = 3;
    @(posedge clk); #1 force_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      rx_byte(b);
      exp_q.push_back(ref_store(b));
    end
    @(negedge clk);
    n_checks++; if (full !== 1'b1) $display("FAIL simul_prefill: got full=%b required 1", full); else n_pass++;
    @(posedge clk); #1 force_busy = 1'b0;
    @(posedge clk); #1 rx_data = 8'hA5; rx_ready = 1'b1;   // FSM is in LOAD this cycle
    exp_q.push_back(ref_store(8'hA5));
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (fifo_count !== DEPTH) $display("FAIL simul_count: got %0d required %0d", fifo_count, DEPTH); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL simul_overflow: got %b required 0", overflow); else n_pass++;
    n = 0;
    while (rx_reset_ready !== 1'b1 && n < 8) begin @(negedge clk); n++; end
    n_checks++; if (rx_reset_ready !== 1'b1) $display("FAIL simul_ack: got %b required 1", rx_reset_ready); else n_pass++;
    @(posedge clk); #1 rx_ready = 1'b0;
    wait_sent(DEPTH + 1, 3000);
    n_checks++; if (sent_q.size() != DEPTH + 1) $display("FAIL simul_sent_count: got %0d required %0d", sent_q.size(), DEPTH + 1); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++) begin
      n_checks++; if (sent_q[i] !== exp_q[i]) $display("FAIL simul_order[%0d]: got %h required %h", i, sent_q[i], exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_timeout;
    logic [7:0] b;
    do_reset;
    tx_auto = 1'b0;                 // transmitter never raises busy
    for (int i = 0; i < 2; i++) begin
      b = 8'($urandom);
      rx_byte(b);
      exp_q.push_back(ref_store(b));
    end
    wait_sent(2, 200);
    n_checks++; if (sent_q.size() != 2) $display("FAIL timeout_sent_count: got %0d required 2", sent_q.size()); else n_pass++;
    if (sent_q.size() == 2) begin
      n_checks++; if (sent_q[0] !== exp_q[0] || sent_q[1] !== exp_q[1]) $display("FAIL timeout_data: got %h %h required %h %h", sent_q[0], sent_q[1], exp_q[0], exp_q[1]); else n_pass++;
      // SEND, BUSY_TIMEOUT cycles of WAIT_BUSY, IDLE, LOAD, then the next SEND
      n_checks++; if (send_cyc[1] - send_cyc[0] != BUSY_TIMEOUT + 3) $display("FAIL timeout_gap: got %0d required %0d", send_cyc[1] - send_cyc[0], BUSY_TIMEOUT + 3); else n_pass++;
    end
    repeat (BUSY_TIMEOUT + 8) @(negedge clk);
    n_checks++; if (overflow !== 1'b0) $display("FAIL timeout_overflow: got %b required 0", overflow); else n_pass++;
    n_checks++; if (empty !== 1'b1) $display("FAIL timeout_empty: got %b required 1", empty); else n_pass++;
  endtask

  task automatic test_reset_midop;
    int bad;
    do_reset;
    tx_auto = 1'b1; tx_delay = 2; tx_len = 40;
    for (int i = 0; i < 6; i++) rx_byte(8'($urandom));   // first issues, five stay queued
    @(negedge clk);
    n_checks++; if (fifo_count !== 5) $display("FAIL midop_queued: got %0d required 5", fifo_count); else n_pass++;
    @(posedge clk); #1;
    rx_data = 8'h3C; rx_ready = 1'b1; reset_n = 1'b0;
    #1;
    n_checks++; if (fifo_count !== 0 || empty !== 1'b1) $display("FAIL midop_count: got count=%0d empty=%b required 0/1", fifo_count, empty); else n_pass++;
    n_checks++; if (tx_send !== 1'b0 || overflow !== 1'b0) $display("FAIL midop_outputs: got send=%b overflow=%b required 0/0", tx_send, overflow); else n_pass++;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (rx_reset_ready !== 1'b0 || fifo_count !== 0 || tx_send !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) $display("FAIL midop_recapture: got %0d active cycles required 0", bad); else n_pass++;
    n_checks++; if (sent_q.size() != 1) $display("FAIL midop_sent_count: got %0d required 1", sent_q.size()); else n_pass++;
    @(posedge clk); #1 rx_ready = 1'b0;
  endtask

  task automatic test_case_fold;
    logic [7:0] vec [6];
    vec = '{8'h61, 8'h7A, 8'h41, 8'h7B, 8'h60, 8'h6D};
    do_reset;
    tx_auto = 1'b1; tx_delay = 1; tx_len = 3;
    for (int i = 0; i < 6; i++) begin
      rx_byte(vec[i]);
      exp_q.push_back(ref_store(vec[i]));
    end
    wait_sent(6, 500);
    n_checks++; if (sent_q.size() != 6) $display("FAIL fold_sent_count: got %0d required 6", sent_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++) begin
      n_checks++; if (sent_q[i] !== exp_q[i]) $display("FAIL fold_data[%0d]: got %h required %h", i, sent_q[i], exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_random;
    logic [7:0] b;
    do_reset;
    tx_auto = 1'b1;
    for (int i = 0; i < 30; i++) begin
      b = 8'($urandom);
      tx_delay = $urandom_range(1, 3);
      tx_len   = $urandom_range(1, 4);
      rx_byte(b);
      exp_q.push_back(ref_store(b));
      repeat ($urandom_range(3, 8)) @(posedge clk);
    end
    wait_sent(30, 3000);
    n_checks++; if (sent_q.size() != 30) $display("FAIL random_sent_count: got %0d required 30", sent_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++) begin
      n_checks++; if (sent_q[i] !== exp_q[i]) $display("FAIL random_data[%0d]: got %h required %h", i, sent_q[i], exp_q[i]); else n_pass++;
    end
    n_checks++; if (overflow !== 1'b0) $display("FAIL random_overflow: got %b required 0", overflow); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_single_byte;
    test_burst;
    test_simultaneous;
    test_timeout;
    test_reset_midop;
    test_case_fold;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached with %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
